pdp8_opr_seq: RTL and testbench
===============================

PDP8_OPR_SEQ -- requirements
Module: pdp8_opr_seq

Interface
REQ-001 Parameter DATA_WIDTH, default 12, sets the width of AC, SR and the rotate path; legal values are even and at least 12.
REQ-002 Parameter ADDR_WIDTH, default 12, sets the PC width.
REQ-003 Parameter BSW_EN, default 0; when 1, byte-swap is enabled for group-1 instructions.
REQ-004 clk  in  1  single clock; all state changes on the rising edge.
REQ-005 reset_n  in  1  asynchronous, active-low reset.
REQ-006 start  in  1  request; sampled only in IDLE.
REQ-007 ir  in  12  operate instruction word (octal 7xxx).
REQ-008 ac_in  in  DATA_WIDTH  accumulator operand; link_in  in  1  link operand.
REQ-009 pc_in  in  ADDR_WIDTH  PC, already incremented past the instruction.
REQ-010 sr_in  in  DATA_WIDTH  switch register, used by OSR.
REQ-011 busy  out  1  high in every state except IDLE.
REQ-012 done  out  1  one-cycle pulse; results are valid in that cycle.
REQ-013 ac_out  out  DATA_WIDTH; link_out  out  1; pc_out  out  ADDR_WIDTH  results.
REQ-014 halt  out  1  HLT executed; illegal  out  1  unsupported encoding; both registered.

Function
REQ-015 The block SHALL capture ir, ac_in, link_in, pc_in and sr_in on the edge where start=1 in IDLE, and then ignore its inputs until it returns to IDLE.
REQ-016 start asserted while busy=1 SHALL be dropped and SHALL NOT be queued.
REQ-017 States: IDLE, G1_CLR, G1_CMP, G1_IAC, G1_ROT1, G1_ROT2, G2_SKIP, G2_CLR, DONE; the block SHALL advance one state per clock, and DONE SHALL go to IDLE.
REQ-018 Decode:
- ir[11:9]!=7 is illegal.
- ir[8]=0 is group 1.
- ir[8]=1 with ir[0]=0 is group 2.
- ir[8]=1 with ir[0]=1 (group 3, MQ) is unsupported and illegal.
- Illegal and group-3 instructions SHALL go IDLE->DONE with illegal=1 and all results equal to the captured inputs.
REQ-019 Group-1 sequence, bit ordering fixed:
- G1_CLR: CLA (ir[7]) clears AC; CLL (ir[6]) clears L.
- G1_CMP: CMA (ir[5]) inverts AC; CML (ir[4]) inverts L.
- G1_IAC: IAC (ir[0]) does AC+1 modulo 2^DATA_WIDTH, and a carry-out complements L.
- G1_ROT1: RAR (ir[3]) or RAL (ir[2]) rotates the (DATA_WIDTH+1)-bit word {L,AC} by one.
- G1_ROT2: entered only when ir[1]=1 and exactly one rotate bit is set; repeats the rotate.
REQ-020 ir[1]=1 with ir[3:2]=0 is BSW:
- With BSW_EN=1, G1_ROT1 SHALL swap the AC halves and leave L unchanged.
- With BSW_EN=0, no operation occurs.
REQ-021 ir[3] and ir[2] both set SHALL perform no rotate and SHALL set illegal=1; the other group-1 steps still execute.
REQ-022 Group-1 latency: done SHALL be high 5 clocks after the start edge, or 6 when G1_ROT2 is used.
REQ-023 G2_SKIP SHALL evaluate the captured AC and L as c = (ir[6]&AC[msb]) | (ir[5]&(AC==0)) | (ir[4]&L), and skip = c XOR ir[3].
REQ-024 On skip, pc_out SHALL be pc_in+1 modulo 2^ADDR_WIDTH (pc_in=all-ones gives 0); otherwise pc_out=pc_in.
REQ-025 G2_CLR:
- CLA (ir[7]) clears AC first.
- OSR (ir[2]) then ORs sr_in into AC.
- HLT (ir[1]) sets halt.
- L is unchanged in group 2.
REQ-026 Group-2 latency SHALL be 3 clocks from the start edge to done.
REQ-027 Group-1 instructions SHALL leave pc_out=pc_in.
REQ-028 ac_out, link_out and pc_out SHALL hold their values from done until the next accepted start.
REQ-029 halt and illegal SHALL hold until the next accepted start clears them, or until reset.

Reset
REQ-030 While reset_n=0, the block SHALL force state to IDLE and drive busy, done, halt, illegal, ac_out, link_out and pc_out to 0, asynchronously.
REQ-031 Assertion of reset_n mid-operation SHALL discard the in-flight instruction, and no done pulse SHALL follow.
REQ-032 The first start SHALL be accepted on the first rising edge after reset_n deasserts.

Verification
REQ-033 CIA 7041, AC=0005, L=0 -> done at +5 cycles, AC=7773, L=0, pc_out=pc_in.
REQ-034 IAC 7001, AC=7777, L=0 -> AC=0000, L=1; RTL 7006, AC=4001, L=0 -> AC=0005, L=0, done at +6 cycles.
REQ-035 SZA 7440, AC=0, pc_in=0201 -> pc_out=0202 at +3 cycles; SNA 7450, same operands -> pc_out=0201; SKP 7410, pc_in=7777 -> pc_out=0000.
REQ-036 7604 (CLA OSR), sr_in=1234 -> AC=1234; HLT 7402 -> halt=1, held until the next start, then cleared.
REQ-037 DATA_WIDTH=16, BSW_EN=1, ir=7002, AC=0x12AB -> AC=0xAB12, L unchanged; ir=5000 -> illegal=1, done at +1 cycle, outputs equal the inputs.
REQ-038 Second start during busy -> ignored, exactly one done pulse; reset_n low at G1_IAC -> all outputs 0, no done pulse, next start executes normally.

Source files
------------

// File: rtl/pdp8_opr_seq.sv
// PDP-8 operate-instruction (group 1 / group 2) micro-sequencer.
// Steps one micro-operation per clock on a captured copy of the operands.
module pdp8_opr_seq #(
  parameter int unsigned DATA_WIDTH = 12,
  parameter int unsigned ADDR_WIDTH = 12,
  parameter bit          BSW_EN     = 1'b0
) (
  input  logic                  i_clk,
  input  logic                  i_reset_n,
  input  logic                  i_start,
  input  logic [11:0]           i_ir,
  input  logic [DATA_WIDTH-1:0] i_ac_in,
  input  logic                  i_link_in,
  input  logic [ADDR_WIDTH-1:0] i_pc_in,
  input  logic [DATA_WIDTH-1:0] i_sr_in,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [DATA_WIDTH-1:0] o_ac_out,
  output logic                  o_link_out,
  output logic [ADDR_WIDTH-1:0] o_pc_out,
  output logic                  o_halt,
  output logic                  o_illegal
);

  localparam int unsigned HalfW = DATA_WIDTH / 2;

  typedef enum logic [3:0] {
    StIdle, StG1Clr, StG1Cmp, StG1Iac, StG1Rot1, StG1Rot2, StG2Skip, StG2Clr, StDone
  } state_e;

  state_e                r_state, w_state_d;
  logic [7:0]            r_ir;
  logic [DATA_WIDTH-1:0] r_ac, w_ac_d, r_sr;
  logic                  r_l, w_l_d;
  logic [ADDR_WIDTH-1:0] r_pc, w_pc_d;
  logic                  r_ill, w_ill_d, r_hlt, w_hlt_d;
  logic                  r_done, r_link_out, r_halt, r_illegal;
  logic [DATA_WIDTH-1:0] r_ac_out;
  logic [ADDR_WIDTH-1:0] r_pc_out;

  logic                  w_accept, w_skip;
  logic [DATA_WIDTH:0]   w_inc;
  logic [DATA_WIDTH-1:0] w_rar_ac, w_ral_ac, w_bsw_ac;

  assign w_accept = (r_state == StIdle) && i_start;
  assign w_inc    = {1'b0, r_ac} + {{DATA_WIDTH{1'b0}}, 1'b1};
  // Rotates act on the (DATA_WIDTH+1)-bit word {L,AC}.
  assign w_rar_ac = {r_l, r_ac[DATA_WIDTH-1:1]};
  assign w_ral_ac = {r_ac[DATA_WIDTH-2:0], r_l};
  assign w_bsw_ac = {r_ac[HalfW-1:0], r_ac[DATA_WIDTH-1:HalfW]};
  assign w_skip   = ((r_ir[6] & r_ac[DATA_WIDTH-1]) | (r_ir[5] & (r_ac == '0)) | (r_ir[4] & r_l))
                    ^ r_ir[3];

  always_comb begin
    w_state_d = r_state;
    w_ac_d    = r_ac;
    w_l_d     = r_l;
    w_pc_d    = r_pc;
    w_ill_d   = r_ill;
    w_hlt_d   = r_hlt;
    unique case (r_state)
      StIdle: begin
        if (i_start) begin
          w_ac_d  = i_ac_in;
          w_l_d   = i_link_in;
          w_pc_d  = i_pc_in;
          w_ill_d = 1'b0;
          w_hlt_d = 1'b0;
          // Non-operate words and group 3 (MQ) skip straight to completion.
          if ((i_ir[11:9] != 3'b111) || (i_ir[8] && i_ir[0])) begin
            w_ill_d   = 1'b1;
            w_state_d = StDone;
          end else if (!i_ir[8]) begin
            w_state_d = StG1Clr;
          end else begin
            w_state_d = StG2Skip;
          end
        end
      end
      StG1Clr: begin
        if (r_ir[7]) w_ac_d = '0;
        if (r_ir[6]) w_l_d = 1'b0;
        w_state_d = StG1Cmp;
      end
      StG1Cmp: begin
        if (r_ir[5]) w_ac_d = ~r_ac;
        if (r_ir[4]) w_l_d = ~r_l;
        w_state_d = StG1Iac;
      end
      StG1Iac: begin
        if (r_ir[0]) begin
          w_ac_d = w_inc[DATA_WIDTH-1:0];
          if (w_inc[DATA_WIDTH]) w_l_d = ~r_l;
        end
        w_state_d = StG1Rot1;
      end
      StG1Rot1: begin
        unique case (r_ir[3:2])
          2'b10: begin w_ac_d = w_rar_ac; w_l_d = r_ac[0]; end
          2'b01: begin w_ac_d = w_ral_ac; w_l_d = r_ac[DATA_WIDTH-1]; end
          2'b11: w_ill_d = 1'b1;
          default: if (r_ir[1] && BSW_EN) w_ac_d = w_bsw_ac;
        endcase
        w_state_d = (r_ir[1] && (r_ir[3] ^ r_ir[2])) ? StG1Rot2 : StDone;
      end
      StG1Rot2: begin
        if (r_ir[3]) begin
          w_ac_d = w_rar_ac;
          w_l_d  = r_ac[0];
        end else begin
          w_ac_d = w_ral_ac;
          w_l_d  = r_ac[DATA_WIDTH-1];
        end
        w_state_d = StDone;
      end
      StG2Skip: begin
        if (w_skip) w_pc_d = r_pc + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
        w_state_d = StG2Clr;
      end
      StG2Clr: begin
        w_ac_d    = (r_ir[7] ? '0 : r_ac) | (r_ir[2] ? r_sr : '0);
        w_hlt_d   = r_ir[1];
        w_state_d = StDone;
      end
      StDone:  w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state    <= StIdle;
      r_ir       <= '0;
      r_ac       <= '0;
      r_sr       <= '0;
      r_l        <= 1'b0;
      r_pc       <= '0;
      r_ill      <= 1'b0;
      r_hlt      <= 1'b0;
      r_done     <= 1'b0;
      r_ac_out   <= '0;
      r_link_out <= 1'b0;
      r_pc_out   <= '0;
      r_halt     <= 1'b0;
      r_illegal  <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_ac    <= w_ac_d;
      r_l     <= w_l_d;
      r_pc    <= w_pc_d;
      r_ill   <= w_ill_d;
      r_hlt   <= w_hlt_d;
      r_done  <= (r_state == StDone);
      if (w_accept) begin
        r_ir      <= i_ir[7:0];
        r_sr      <= i_sr_in;
        r_halt    <= 1'b0;
        r_illegal <= 1'b0;
      end
      if (r_state == StDone) begin
        r_ac_out   <= r_ac;
        r_link_out <= r_l;
        r_pc_out   <= r_pc;
        r_halt     <= r_hlt;
        r_illegal  <= r_ill;
      end
    end
  end

  assign o_busy     = (r_state != StIdle);
  assign o_done     = r_done;
  assign o_ac_out   = r_ac_out;
  assign o_link_out = r_link_out;
  assign o_pc_out   = r_pc_out;
  assign o_halt     = r_halt;
  assign o_illegal  = r_illegal;

endmodule

// File: tb/tb_pdp8_opr_seq.sv
// Directed bench for pdp8_opr_seq: a 12-bit default instance and a 16-bit BSW instance
// share stimulus; each vector checks latency, pulse count and results of one instance.
module tb_pdp8_opr_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic [11:0] ir = '0;
  logic        link = 1'b0;
  logic [11:0] pc = '0;
  logic [15:0] ac = '0;
  logic [15:0] sr = '0;

  logic        a_busy, a_done, a_l, a_halt, a_ill;
  logic [11:0] a_ac, a_pc;
  logic        b_busy, b_done, b_l, b_halt, b_ill;
  logic [15:0] b_ac;
  logic [11:0] b_pc;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pdp8_opr_seq u_dut12 (
    .i_clk(clk), .i_reset_n(rst_n), .i_start(start), .i_ir(ir), .i_ac_in(ac[11:0]),
    .i_link_in(link), .i_pc_in(pc), .i_sr_in(sr[11:0]), .o_busy(a_busy), .o_done(a_done),
    .o_ac_out(a_ac), .o_link_out(a_l), .o_pc_out(a_pc), .o_halt(a_halt), .o_illegal(a_ill)
  );

  pdp8_opr_seq #(.DATA_WIDTH(16), .ADDR_WIDTH(12), .BSW_EN(1'b1)) u_dut16 (
    .i_clk(clk), .i_reset_n(rst_n), .i_start(start), .i_ir(ir), .i_ac_in(ac),
    .i_link_in(link), .i_pc_in(pc), .i_sr_in(sr), .o_busy(b_busy), .o_done(b_done),
    .o_ac_out(b_ac), .o_link_out(b_l), .o_pc_out(b_pc), .o_halt(b_halt), .o_illegal(b_ill)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Apply one instruction, then watch a bounded window for the done pulse.
  task automatic run(input bit sel, input string tag, input logic [11:0] t_ir,
                     input logic [15:0] t_ac, input logic t_l, input logic [11:0] t_pc,
                     input logic [15:0] t_sr, input int lat, input logic [15:0] e_ac,
                     input logic e_l, input logic [11:0] e_pc, input logic e_hlt,
                     input logic e_ill);
    int seen = -1;
    int pulses = 0;
    @(negedge clk);
    ir = t_ir; ac = t_ac; link = t_l; pc = t_pc; sr = t_sr; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    chk({tag, ".busy"}, sel ? b_busy : a_busy, 1'b1);
    chk({tag, ".clr"}, sel ? {b_halt, b_ill} : {a_halt, a_ill}, 2'b00);
    for (int i = 1; i <= 10; i++) begin
      @(posedge clk);
      #1;
      if (sel ? b_done : a_done) begin
        pulses++;
        if (seen < 0) seen = i;
      end
    end
    chk({tag, ".lat"}, seen, lat);
    chk({tag, ".pulses"}, pulses, 1);
    chk({tag, ".ac"}, sel ? b_ac : {4'h0, a_ac}, e_ac);
    chk({tag, ".l"}, sel ? b_l : a_l, e_l);
    chk({tag, ".pc"}, sel ? b_pc : a_pc, e_pc);
    chk({tag, ".halt"}, sel ? b_halt : a_halt, e_hlt);
    chk({tag, ".ill"}, sel ? b_ill : a_ill, e_ill);
  endtask

  initial begin
    int pulses;
    #1 rst_n = 1'b0;
    #2;
    chk("rst.a", {a_busy, a_done, a_ac, a_l, a_pc, a_halt, a_ill}, '0);
    chk("rst.b", {b_busy, b_done, b_ac, b_l, b_pc, b_halt, b_ill}, '0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Group 1 (octal encodings)
    run(0, "cia",   12'o7041, 16'o0005, 0, 12'o0100, 0, 5, 16'o7773, 0, 12'o0100, 0, 0);
    run(0, "iac",   12'o7001, 16'o7777, 0, 12'o0100, 0, 5, 16'o0000, 1, 12'o0100, 0, 0);
    run(0, "rtl",   12'o7006, 16'o4001, 0, 12'o0100, 0, 6, 16'o0005, 0, 12'o0100, 0, 0);
    run(0, "rar",   12'o7010, 16'o0001, 0, 12'o0110, 0, 5, 16'o0000, 1, 12'o0110, 0, 0);
    run(0, "rarl",  12'o7214, 16'o1234, 1, 12'o0120, 0, 5, 16'o0000, 1, 12'o0120, 0, 1);
    run(0, "cllcml", 12'o7120, 16'o0055, 0, 12'o0130, 0, 5, 16'o0055, 1, 12'o0130, 0, 0);
    run(0, "bsw0",  12'o7002, 16'o1234, 0, 12'o0140, 0, 5, 16'o1234, 0, 12'o0140, 0, 0);
    // Group 2
    run(0, "sza",   12'o7440, 16'o0000, 0, 12'o0201, 0, 3, 16'o0000, 0, 12'o0202, 0, 0);
    run(0, "sna",   12'o7450, 16'o0000, 0, 12'o0201, 0, 3, 16'o0000, 0, 12'o0201, 0, 0);
    run(0, "skp",   12'o7410, 16'o0123, 0, 12'o7777, 0, 3, 16'o0123, 0, 12'o0000, 0, 0);
    run(0, "sma",   12'o7500, 16'o4000, 1, 12'o0300, 0, 3, 16'o4000, 1, 12'o0301, 0, 0);
    run(0, "claosr", 12'o7604, 16'o5555, 0, 12'o0310, 16'o1234, 3, 16'o1234, 0, 12'o0310, 0, 0);
    run(0, "hlt",   12'o7402, 16'o0007, 0, 12'o0320, 0, 3, 16'o0007, 0, 12'o0320, 1, 0);
    repeat (3) @(posedge clk);
    #1 chk("hlt.hold", a_halt, 1'b1);
    run(0, "snl",   12'o7420, 16'o0000, 1, 12'o0010, 0, 3, 16'o0000, 1, 12'o0011, 0, 0);
    // Illegal encodings pass operands through
    run(0, "grp3",  12'o7401, 16'o2222, 1, 12'o0400, 0, 1, 16'o2222, 1, 12'o0400, 0, 1);
    run(0, "nonop", 12'o5000, 16'o3333, 0, 12'o0500, 0, 1, 16'o3333, 0, 12'o0500, 0, 1);
    // 16-bit instance with byte swap
    run(1, "bsw16", 12'o7002, 16'h12AB, 1, 12'o0600, 0, 5, 16'hAB12, 1, 12'o0600, 0, 0);
    run(1, "ral16", 12'o7004, 16'h8001, 0, 12'o0610, 0, 5, 16'h0002, 1, 12'o0610, 0, 0);

    // start held while busy must not queue a second operation
    @(negedge clk);
    ir = 12'o7001; ac = 16'o0005; link = 1'b0; pc = 12'o0100; start = 1'b1;
    @(posedge clk);
    #1 ir = 12'o7200; ac = 16'o7777;
    @(posedge clk);
    @(posedge clk);
    #1 start = 1'b0;
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1 if (a_done) pulses++;
    end
    chk("busy.pulses", pulses, 1);
    chk("busy.ac", a_ac, 12'o0006);

    // Reset in G1_IAC: outputs clear at once, no done afterwards
    @(negedge clk);
    ir = 12'o7001; ac = 16'o0100; pc = 12'o0700; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("mid.rst", {a_busy, a_done, a_ac, a_l, a_pc, a_halt, a_ill}, '0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1 if (a_done) pulses++;
    end
    chk("mid.nodone", pulses, 0);
    run(0, "after", 12'o7001, 16'o0100, 0, 12'o0700, 0, 5, 16'o0101, 0, 12'o0700, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
